// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding and default sizes.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting to see the input low before arming
        ST_ARMED = 2'd1,   // input known low, waiting for the first rise
        ST_HIGH  = 2'd2,   // measuring the high phase
        ST_LOW   = 2'd3    // measuring the low phase, next rise closes the period
    } state_t;

    localparam int unsigned DEF_W           = 32;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Synchronizer chain for an asynchronous input, with one extra delay flop so
// single-cycle rise/fall strobes can be derived in the destination domain.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   level_d;

    // Shift the raw input through the synchronizer, then keep one delayed copy.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            chain   <= '0;
            level_d <= 1'b0;
        end else begin
            chain   <= {chain[SYNC_STAGES-2:0], d};
            level_d <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM / divided-clock input
// in i_clk cycles, and flags loss of signal when no edge arrives in time.
//
// Output handshake: o_valid is a one-cycle strobe with no back-pressure; the
// consumer must take o_period/o_high in the cycle o_valid is high (both also
// hold until the next strobe). o_timeout is a level, cleared with o_valid.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned W           = DEF_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [W-1:0] TIMEOUT    = '1
) (
    input  logic         i_clk,
    input  logic         rst_n,
    input  logic         i_pwm,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_high,
    output logic         o_valid,
    output logic         o_timeout,
    output state_t       dbg_state
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic s, rise, fall;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk (i_clk),
        .rst_n (rst_n),
        .d     (i_pwm),
        .level (s),
        .rise  (rise),
        .fall  (fall)
    );

    // After reset the synchronizer outputs 0 until the real input has walked
    // through it; warm marks when s can be trusted, so an input that is already
    // high at reset release is not mistaken for low-then-rise.
    logic [SYNC_STAGES:0] warm;
    logic                 primed;

    // Fill the warm-up shift register with ones after reset.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) warm <= '0;
        else        warm <= {warm[SYNC_STAGES-1:0], 1'b1};
    end

    assign primed = warm[SYNC_STAGES];

    state_t       state, state_nx;
    logic [W-1:0] cnt, cnt_nx;
    logic [W-1:0] high_cap, high_cap_nx;
    logic [W-1:0] period_nx, high_nx;
    logic         valid_nx, timeout_nx;

    // Register FSM state, counter, captured high time and all outputs.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            high_cap  <= '0;
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            high_cap  <= high_cap_nx;
            o_period  <= period_nx;
            o_high    <= high_nx;
            o_valid   <= valid_nx;
            o_timeout <= timeout_nx;
        end
    end

    // Next-state, counter and result logic; an edge takes priority over timeout.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        high_cap_nx = high_cap;
        period_nx   = o_period;
        high_nx     = o_high;
        valid_nx    = 1'b0;
        timeout_nx  = o_timeout;

        // Counter restarts at 1 on each rise; it saturates at TIMEOUT so a
        // late edge in the timeout cycle still cannot wrap it.
        if (rise) begin
            cnt_nx = CNT_ONE;
        end else if ((state == ST_HIGH || state == ST_LOW) && cnt != TIMEOUT) begin
            cnt_nx = cnt + CNT_ONE;
        end

        case (state)
            ST_IDLE: begin
                if (primed && !s) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
                if (rise) state_nx = ST_HIGH;
            end
            ST_HIGH: begin
                if (fall) begin
                    state_nx    = ST_LOW;
                    high_cap_nx = cnt;
                end else if (cnt == TIMEOUT) begin
                    state_nx   = ST_IDLE;
                    timeout_nx = 1'b1;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_nx   = ST_HIGH;
                    period_nx  = cnt;
                    high_nx    = high_cap;
                    valid_nx   = 1'b1;
                    timeout_nx = 1'b0;
                end else if (cnt == TIMEOUT) begin
                    state_nx   = ST_IDLE;
                    timeout_nx = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

- Measures an external PWM or slow-clock signal, sampled in the `i_clk` domain.
- For every complete cycle it reports:
  - the period, in `i_clk` cycles, between consecutive rising edges;
  - the high time, in `i_clk` cycles, from a rising edge to the next falling edge.
- Sits at the receiving end of the PWM/divided-clock path: feedback for the PWM driver, or a loopback checker on its own divided-clock and PWM outputs.
- Flags loss of signal (input stuck high or stuck low) with a timeout.

## Interface

Parameters:
- `W`, 32: counter and result width.
- `SYNC_STAGES`, 2: synchronizer depth, ≥2.
- `TIMEOUT`, 2^W−1: cycle count without an edge before loss is declared; must be ≤ 2^W−1.

Ports:
- `i_clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_pwm`  in  1  asynchronous PWM input.
- `o_period`  out  W  last measured period, in `i_clk` cycles.
- `o_high`  out  W  last measured high time, in `i_clk` cycles.
- `o_valid`  out  1  one-cycle pulse when `o_period`/`o_high` update.
- `o_timeout`  out  1  level; loss of signal.

## Operation

Input conditioning:
- `i_pwm` passes through a `SYNC_STAGES` flop chain giving `s`, then one more flop giving `s_d`.
- rise = `s & ~s_d`; fall = `~s & s_d`.

Counter `cnt` (W bits):
- Loaded with 1 on every rise.
- Otherwise increments by 1 each cycle while in HIGH or LOW.
- Never wraps: `TIMEOUT` ≤ 2^W−1 guarantees this.

State machine states: IDLE, ARMED, HIGH, LOW.
- IDLE:
  - `s == 0` → ARMED.
  - This rejects a synchronizer 0→1 after reset or after a timeout with the input already high.
- ARMED:
  - rise → HIGH, `cnt` ← 1.
- HIGH:
  - fall → LOW, high_cap ← `cnt`.
  - Else if `cnt == TIMEOUT` → IDLE, `o_timeout` ← 1.
- LOW:
  - rise → HIGH, `o_period` ← `cnt`, `o_high` ← high_cap, `o_valid` ← 1, `o_timeout` ← 0, `cnt` ← 1.
  - Else if `cnt == TIMEOUT` → IDLE, `o_timeout` ← 1.

Rules:
- An edge and `cnt == TIMEOUT` in the same cycle: the edge wins.
- Results hold their last value until the next valid measurement; timeout does not clear them.
- First `o_valid` after reset or timeout comes at the second detected rise after arming. There is no partial measurement.
- Glitches:
  - A 1-cycle high pulse that survives synchronization measures high = 1.
  - Pulses shorter than one `i_clk` period may be missed. This is acceptable.
- Reset mid-measurement:
  - All state is discarded and the FSM returns to IDLE.
  - Outputs go to reset values immediately (asynchronously).

## Timing

- Reset values:
  - `o_period` = 0, `o_high` = 0, `o_valid` = 0, `o_timeout` = 0.
  - Synchronizer flops, `s_d`, `cnt` and high_cap = 0; state = IDLE.
- Detection latency: an input edge is seen as rise/fall `SYNC_STAGES`+1 cycles after it is sampled.
- Output latency:
  - `o_valid` asserts in the cycle after the rise is detected, i.e. `SYNC_STAGES`+2 cycles after the closing rising edge of `i_pwm`.
  - `o_valid` lasts exactly 1 cycle.
  - `o_period`/`o_high` are stable from that cycle onward.
- Resolution:
  - period = t_rise(n+1) − t_rise(n), and high = t_fall − t_rise(n), both in `i_clk` cycles at detection.
  - Accuracy is ±1 cycle due to synchronization.
- Timeout assertion:
  - `o_timeout` goes to 1 in the cycle after `cnt` reaches `TIMEOUT`.
  - It stays 1 until the next `o_valid`, where it clears in the same cycle.
- Back-to-back: periods as short as 2 cycles (high 1, low 1) are measured without loss. `o_valid` may then pulse every 2 cycles.

## Structure

- Shared package `pwm_pkg`:
  - state encoding (IDLE, ARMED, HIGH, LOW, 2-bit);
  - default `W`;
  - default `SYNC_STAGES`.
- Sub-module `sync_edge`:
  - parameter `SYNC_STAGES`;
  - input `d`;
  - outputs `level`, `rise`, `fall`;
  - reusable by other blocks that take external inputs.
- Top level holds the FSM, counter, capture registers and output registers.

## Test plan

- Reset, no stimulus:
  - all outputs 0 for 1000 cycles;
  - `o_timeout` stays 0, because the FSM never leaves ARMED.
- `i_pwm` period 10, high 3, aligned to `i_clk`:
  - first `o_valid` at the second rise;
  - `o_period` = 10, `o_high` = 3 on every pulse;
  - exactly one `o_valid` per period.
- `TIMEOUT` = 50, PWM running, then input held high:
  - `o_timeout` = 1 within 51 cycles of the last rise detection;
  - results keep the last values;
  - resume PWM → `o_timeout` clears with the next `o_valid`.
- `i_pwm` = 1 during and after reset release:
  - no `o_valid` until the input goes low and two full rises follow.
- Duty change mid-stream (high 3 → 7, period 10):
  - the next complete cycle reports `o_high` = 7, `o_period` = 10.
- Minimum period 2 (toggle every cycle):
  - `o_period` = 2, `o_high` = 1;
  - `o_valid` every 2 cycles.
- Reset asserted mid-HIGH:
  - outputs 0 immediately;
  - after release, no stale result.
